// File: rtl/pht_pkg.sv
// ----------------------------------------------------------------------------
// pht_pkg: shared types and default widths for the PHT write scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pht_pkg;

  localparam int unsigned PHT_INDEX_WIDTH   = 8;
  localparam int unsigned PHT_COUNTER_WIDTH = 2;
  localparam int unsigned PHT_QUEUE_DEPTH   = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pht_state_e;

  // Commit-queue entry layout at the default widths.
  typedef struct packed {
    logic                         valid;
    logic [PHT_INDEX_WIDTH-1:0]   index;
    logic [PHT_COUNTER_WIDTH-1:0] count;
  } pht_entry_t;

endpackage

`default_nettype wire

// File: rtl/pht_commit_queue.sv
// ----------------------------------------------------------------------------
// pht_commit_queue: circular commit-update FIFO with invalidate-by-index and
// youngest-match read bypass. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pht_commit_queue
  import pht_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH   = PHT_INDEX_WIDTH,
  parameter int unsigned COUNTER_WIDTH = PHT_COUNTER_WIDTH,
  parameter int unsigned QUEUE_DEPTH   = PHT_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [INDEX_WIDTH-1:0]   push_index_i,
  input  logic [COUNTER_WIDTH-1:0] push_count_i,
  input  logic                     pop_i,
  input  logic                     inv_i,
  input  logic [INDEX_WIDTH-1:0]   inv_index_i,
  input  logic [INDEX_WIDTH-1:0]   rd_index_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     head_valid_o,
  output logic [INDEX_WIDTH-1:0]   head_index_o,
  output logic [COUNTER_WIDTH-1:0] head_count_o,
  output logic                     hit_o,
  output logic [COUNTER_WIDTH-1:0] hit_count_o
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef struct packed {
    logic                     valid;
    logic [INDEX_WIDTH-1:0]   index;
    logic [COUNTER_WIDTH-1:0] count;
  } entry_t;

  entry_t           ent_q [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic [PTR_W-1:0] slot;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (inv_i && ent_q[i].valid && (ent_q[i].index == inv_index_i)) begin
          ent_q[i].valid <= 1'b0;
        end
      end
      // Popped slots drop their valid bit so the bypass never sees them again.
      if (pop_i) begin
        ent_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q              <= rd_ptr_q + PTR_W'(1);
      end
      if (push_i) begin
        ent_q[wr_ptr_q] <= '{valid: 1'b1, index: push_index_i, count: push_count_i};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit_o       = 1'b0;
    hit_count_o = '0;
    slot        = rd_ptr_q;
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      slot = rd_ptr_q + PTR_W'(k);
      if (ent_q[slot].valid && (ent_q[slot].index == rd_index_i)) begin
        hit_o       = 1'b1;
        hit_count_o = ent_q[slot].count;
      end
    end
  end

  assign full_o       = (occ_q == OCC_W'(QUEUE_DEPTH));
  assign empty_o      = (occ_q == '0);
  assign head_valid_o = ent_q[rd_ptr_q].valid;
  assign head_index_o = ent_q[rd_ptr_q].index;
  assign head_count_o = ent_q[rd_ptr_q].count;

endmodule

`default_nettype wire

// File: rtl/pht_write_scheduler.sv
// ----------------------------------------------------------------------------
// pht_write_scheduler: owns the PHT write port; arbitrates init sweep,
// rollback restores and queued commit updates. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pht_write_scheduler
  import pht_pkg::*;
#(
  parameter int unsigned              INDEX_WIDTH   = PHT_INDEX_WIDTH,
  parameter int unsigned              COUNTER_WIDTH = PHT_COUNTER_WIDTH,
  parameter int unsigned              QUEUE_DEPTH   = PHT_QUEUE_DEPTH,
  parameter logic [COUNTER_WIDTH-1:0] INIT_COUNT    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_req,
  output logic                     busy,
  input  logic                     rb_valid,
  input  logic [INDEX_WIDTH-1:0]   rb_index,
  input  logic [COUNTER_WIDTH-1:0] rb_count,
  input  logic                     cm_valid,
  output logic                     cm_ready,
  input  logic [INDEX_WIDTH-1:0]   cm_index,
  input  logic [COUNTER_WIDTH-1:0] cm_count,
  output logic                     wr_en,
  output logic [INDEX_WIDTH-1:0]   wr_index,
  output logic [COUNTER_WIDTH-1:0] wr_count,
  input  logic [INDEX_WIDTH-1:0]   rd_index,
  output logic                     rd_hit,
  output logic [COUNTER_WIDTH-1:0] rd_count
);

  pht_state_e               state_q;
  logic [INDEX_WIDTH-1:0]   idx_q;
  logic                     run;
  logic                     q_full;
  logic                     q_empty;
  logic                     q_head_valid;
  logic [INDEX_WIDTH-1:0]   q_head_index;
  logic [COUNTER_WIDTH-1:0] q_head_count;
  logic                     q_hit;
  logic [COUNTER_WIDTH-1:0] q_hit_count;
  logic                     q_pop;
  logic                     q_push;
  logic                     q_clear;
  logic                     q_inv;

  assign run = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_INIT, ST_FLUSH: begin
          if (flush_req) begin
            state_q <= ST_FLUSH;
            idx_q   <= '0;
          end else if (idx_q == {INDEX_WIDTH{1'b1}}) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + INDEX_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (flush_req) begin
            state_q <= ST_FLUSH;
            idx_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_INIT;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Write-port priority: sweep, then rollback, then queue head. A flush cycle
  // leaves the queue untouched since its contents are about to be discarded.
  always_comb begin
    wr_en    = 1'b0;
    wr_index = '0;
    wr_count = '0;
    q_pop    = 1'b0;
    if (rst_n) begin
      if (!run) begin
        wr_en    = 1'b1;
        wr_index = idx_q;
        wr_count = INIT_COUNT;
      end else if (rb_valid) begin
        wr_en    = 1'b1;
        wr_index = rb_index;
        wr_count = rb_count;
      end else if (!q_empty && !flush_req) begin
        q_pop = 1'b1;
        wr_en = q_head_valid;
        if (q_head_valid) begin
          wr_index = q_head_index;
          wr_count = q_head_count;
        end
      end
    end
  end

  assign busy     = !rst_n || !run;
  assign cm_ready = rst_n && run && !q_full;
  assign q_push   = cm_valid && cm_ready;
  assign q_clear  = run && flush_req;
  assign q_inv    = rst_n && run && rb_valid;
  assign rd_hit   = rst_n && q_hit;
  assign rd_count = rd_hit ? q_hit_count : '0;

  pht_commit_queue #(
    .INDEX_WIDTH   (INDEX_WIDTH),
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .QUEUE_DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (q_clear),
    .push_i       (q_push),
    .push_index_i (cm_index),
    .push_count_i (cm_count),
    .pop_i        (q_pop),
    .inv_i        (q_inv),
    .inv_index_i  (rb_index),
    .rd_index_i   (rd_index),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_valid_o (q_head_valid),
    .head_index_o (q_head_index),
    .head_count_o (q_head_count),
    .hit_o        (q_hit),
    .hit_count_o  (q_hit_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_pht_write_scheduler.sv
// ----------------------------------------------------------------------------
// tb_pht_write_scheduler: directed scoreboard bench for pht_write_scheduler.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pht_write_scheduler;

  localparam int unsigned IW = 3;
  localparam int unsigned CW = 2;
  localparam int unsigned QD = 4;
  localparam logic [CW-1:0] INIT_CNT = 2'd1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_req = 1'b0;
  logic          busy;
  logic          rb_valid = 1'b0;
  logic [IW-1:0] rb_index = '0;
  logic [CW-1:0] rb_count = '0;
  logic          cm_valid = 1'b0;
  logic          cm_ready;
  logic [IW-1:0] cm_index = '0;
  logic [CW-1:0] cm_count = '0;
  logic          wr_en;
  logic [IW-1:0] wr_index;
  logic [CW-1:0] wr_count;
  logic [IW-1:0] rd_index = '0;
  logic          rd_hit;
  logic [CW-1:0] rd_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t exp_q[$];

  pht_write_scheduler #(
    .INDEX_WIDTH   (IW),
    .COUNTER_WIDTH (CW),
    .QUEUE_DEPTH   (QD),
    .INIT_COUNT    (INIT_CNT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_req (flush_req),
    .busy      (busy),
    .rb_valid  (rb_valid),
    .rb_index  (rb_index),
    .rb_count  (rb_count),
    .cm_valid  (cm_valid),
    .cm_ready  (cm_ready),
    .cm_index  (cm_index),
    .cm_count  (cm_count),
    .wr_en     (wr_en),
    .wr_index  (wr_index),
    .wr_count  (wr_count),
    .rd_index  (rd_index),
    .rd_hit    (rd_hit),
    .rd_count  (rd_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1);
  end

  // Every table write is matched in order against the expected-write queue.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got idx=%0d cnt=%0d, expected no write", wr_index, wr_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (wr_index !== e.idx || wr_count !== e.cnt) begin
          n_bad++;
          $display("FAIL table_write: got idx=%0d cnt=%0d, expected idx=%0d cnt=%0d",
                   wr_index, wr_count, e.idx, e.cnt);
        end
      end
    end
  end

  task automatic exp_w(input int i, input int c);
    exp_t e;
    e.idx = IW'(i);
    e.cnt = CW'(c);
    exp_q.push_back(e);
  endtask

  task automatic exp_sweep(input int last);
    for (int i = 0; i <= last; i++) exp_w(i, int'(INIT_CNT));
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    cyc();
    #1;
    chk("rst_busy", 32'(busy), 1);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_cm_ready", 32'(cm_ready), 0);
    chk("rst_rd_hit", 32'(rd_hit), 0);
    chk("rst_wr_index", 32'(wr_index), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_rd_count", 32'(rd_count), 0);
    cyc();

    // Initial sweep of 8 entries
    exp_sweep(7);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("sweep_busy", 32'(busy), 1);
      chk("sweep_cm_ready", 32'(cm_ready), 0);
      cyc();
    end
    #1;
    chk("run_busy", 32'(busy), 0);
    chk("run_cm_ready", 32'(cm_ready), 1);

    // Fill the queue behind a held rollback
    rb_valid = 1'b1; rb_index = 3'd0; rb_count = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cm_valid = 1'b1; cm_index = IW'(i); cm_count = 2'd3;
      exp_w(0, 0);
      cyc();
    end
    cm_valid = 1'b0; rd_index = 3'd3;
    exp_w(0, 0);
    #1;
    chk("full_cm_ready", 32'(cm_ready), 0);
    chk("full_rd_hit", 32'(rd_hit), 1);
    chk("full_rd_count", 32'(rd_count), 3);
    cyc();
    rb_valid = 1'b0;
    for (int i = 1; i <= 4; i++) exp_w(i, 3);
    repeat (4) cyc();
    #1;
    chk("drained_rd_hit", 32'(rd_hit), 0);
    chk("drained_cm_ready", 32'(cm_ready), 1);

    // Bypass of a single commit
    cm_valid = 1'b1; cm_index = 3'd5; cm_count = 2'd2; rd_index = 3'd5;
    exp_w(5, 2);
    #1;
    chk("same_cycle_no_bypass", 32'(rd_hit), 0);
    cyc();
    cm_valid = 1'b0;
    #1;
    chk("bypass_hit", 32'(rd_hit), 1);
    chk("bypass_count", 32'(rd_count), 2);
    cyc();
    #1;
    chk("bypass_retired", 32'(rd_hit), 0);

    // Rollback supersedes a queued commit to the same index
    cm_valid = 1'b1; cm_index = 3'd6; cm_count = 2'd3;
    rb_valid = 1'b1; rb_index = 3'd0; rb_count = 2'd2;
    exp_w(0, 2);
    cyc();
    cm_valid = 1'b0; rb_index = 3'd6; rb_count = 2'd1; rd_index = 3'd6;
    exp_w(6, 1);
    #1;
    chk("pre_rb_hit", 32'(rd_hit), 1);
    chk("pre_rb_count", 32'(rd_count), 3);
    cyc();
    rb_valid = 1'b0;
    #1;
    chk("invalid_pop_wr_en", 32'(wr_en), 0);
    chk("invalidated_rd_hit", 32'(rd_hit), 0);
    cyc();
    #1;
    chk("idle_wr_en", 32'(wr_en), 0);

    // Flush in RUN with two queued entries and a concurrent rollback
    rb_valid = 1'b1; rb_index = 3'd0; rb_count = 2'd3; rd_index = 3'd1;
    for (int i = 1; i <= 2; i++) begin
      cm_valid = 1'b1; cm_index = IW'(i); cm_count = 2'd2;
      exp_w(0, 3);
      cyc();
    end
    cm_valid = 1'b0; flush_req = 1'b1;
    exp_w(0, 3);
    exp_sweep(7);
    #1;
    chk("flush_cycle_busy", 32'(busy), 0);
    chk("queued_rd_hit", 32'(rd_hit), 1);
    cyc();
    flush_req = 1'b0; rb_index = 3'd3; rb_count = 2'd0;
    #1;
    chk("flush_busy", 32'(busy), 1);
    chk("flush_cm_ready", 32'(cm_ready), 0);
    chk("flush_rd_hit", 32'(rd_hit), 0);
    cyc();
    rb_valid = 1'b0;
    repeat (7) cyc();
    #1;
    chk("post_flush_busy", 32'(busy), 0);
    chk("post_flush_cm_ready", 32'(cm_ready), 1);
    chk("post_flush_rd_hit", 32'(rd_hit), 0);

    // flush_req mid-sweep at idx 5 restarts the sweep
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    exp_sweep(5);
    exp_sweep(7);
    repeat (5) cyc();
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    repeat (7) cyc();
    #1;
    chk("restart_busy_last", 32'(busy), 1);
    cyc();
    #1;
    chk("restart_busy_done", 32'(busy), 0);

    // Reset pulse mid-sweep
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    exp_sweep(2);
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_busy", 32'(busy), 1);
    chk("midrst_wr_index", 32'(wr_index), 0);
    cyc();
    rst_n = 1'b1;
    exp_sweep(7);
    repeat (7) cyc();
    #1;
    chk("rst_restart_busy_last", 32'(busy), 1);
    cyc();
    #1;
    chk("rst_restart_busy_done", 32'(busy), 0);

    repeat (2) cyc();
    chk("all_writes_seen", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pht_write_scheduler.md
# pht_write_scheduler

Write-port scheduler and initialiser for the branch-history prediction table. It owns the table's single shared write port and sequences it between three sources: the table-initialisation sweep, rollback restores from the ID/EX stages, and buffered commit-time counter updates. Commit updates wait in a small queue with read bypass, so the fetch-stage lookup never sees a stale counter. The block sits between the history predictor's update logic and the prediction table storage.

## Interface
Parameters:
- INDEX_WIDTH, 8, table index width; table depth is 2^INDEX_WIDTH.
- COUNTER_WIDTH, 2, saturating jump-status counter width.
- QUEUE_DEPTH, 4, number of commit-update queue entries; must be a power of two, at least 2.
- INIT_COUNT, 0, counter value written by the sweep.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- flush_req  in  1  single-cycle pulse; re-initialises the whole table.
- busy  out  1  sweep in progress; the front end must stall prediction while high.
- rb_valid  in  1  rollback restore request; always accepted, no ready.
- rb_index  in  INDEX_WIDTH  rollback target index.
- rb_count  in  COUNTER_WIDTH  rollback restore value.
- cm_valid  in  1  commit update request.
- cm_ready  out  1  commit queue not full.
- cm_index  in  INDEX_WIDTH  commit target index.
- cm_count  in  COUNTER_WIDTH  commit new counter value.
- wr_en  out  1  table write enable.
- wr_index  out  INDEX_WIDTH  table write index.
- wr_count  out  COUNTER_WIDTH  table write data.
- rd_index  in  INDEX_WIDTH  index of the current fetch lookup.
- rd_hit  out  1  a pending queued write matches rd_index.
- rd_count  out  COUNTER_WIDTH  value of the newest matching pending write.

## Operation
- States: INIT, RUN, FLUSH. INIT and FLUSH behave identically; they are kept separate only for debug visibility.
- INIT/FLUSH sweep:
  - The sweep counter idx starts at 0.
  - Each cycle: wr_en=1, wr_index=idx, wr_count=INIT_COUNT, then idx increments.
  - After index 2^INDEX_WIDTH-1 is written, the block enters RUN.
  - Outputs during the sweep: busy=1, cm_ready=0, rd_hit=0.
  - rb_valid is ignored (dropped) during the sweep.
- RUN, write-port priority (highest first):
  1. Rollback. If rb_valid, the write is a combinational pass-through: wr_en=1, wr_index=rb_index, wr_count=rb_count, in the same cycle.
  2. Queue head. Otherwise, if the queue is non-empty, the head entry is written and popped.
  3. Idle. Otherwise wr_en=0.
- Rollback supersedes commits: on rb_valid, every valid queue entry whose index equals rb_index is invalidated in that cycle, including the head. Invalid entries are popped without issuing a write.
- Commit enqueue occurs on cm_valid & cm_ready.
  - cm_ready = RUN & (occupancy < QUEUE_DEPTH), with occupancy taken from the registered value.
  - An enqueue and a dequeue in the same cycle are both performed.
- Bypass:
  - rd_hit = 1 if any valid queue entry has index == rd_index.
  - rd_count is taken from the youngest matching entry.
  - Same-cycle enqueues and rb_valid are not bypassed.
- flush_req in RUN: the queue is cleared, idx=0, and the state becomes FLUSH on the next cycle.
- flush_req during INIT/FLUSH: the sweep restarts at idx=0.
- flush_req and rb_valid in the same cycle: the rollback write still issues that cycle, then FLUSH follows.

## Timing
- Reset (rst_n=0 at a clock edge) leaves the block in INIT, idx=0, queue empty.
- Output values while rst_n=0:
  - busy=1
  - wr_en=0
  - cm_ready=0
  - rd_hit=0
  - wr_index=0, wr_count=0, rd_count=0
- Sweep length: the first sweep write occurs in the first cycle with rst_n=1. busy falls after exactly 2^INDEX_WIDTH write cycles.
- Reset asserted mid-sweep or mid-RUN discards all state and restarts the sweep.
- Commit latency: a commit accepted in cycle N is written no earlier than N+1. It is delayed one cycle per rb_valid cycle.
- Bypass: an entry is visible on rd_hit from cycle N+1 until the cycle it is written, inclusive.
- Queue pointers wrap modulo QUEUE_DEPTH. Occupancy uses log2(QUEUE_DEPTH)+1 bits.

## Structure
- Package pht_pkg holds:
  - the state enum (INIT, RUN, FLUSH);
  - the queue entry typedef {valid, index, count};
  - the default width constants.
- Sub-module pht_commit_queue: circular FIFO with a per-entry index compare, providing an invalidate-by-index port and a youngest-match bypass output.
- The FSM, sweep counter and priority mux stay in the top level.

## Test plan
- Reset release with INDEX_WIDTH=3 -> wr_en=1 for 8 cycles, wr_index 0..7 with wr_count=INIT_COUNT, then busy=0 and cm_ready=1.
- Fill the queue with 4 commits (idx 1..4, count 3) while rb_valid is held high -> cm_ready=0 after the 4th. Then release rb_valid -> idx 1,2,3,4 are written on consecutive cycles.
- Commit idx 5 count 2, then rd_index=5 -> rd_hit=1, rd_count=2. After the write retires -> rd_hit=0.
- Queue holds idx 6 (count 3), then rb_valid idx 6 count 1 -> a single write of 6/1 is issued; the queued 6/3 is never written.
- flush_req in RUN with 2 entries queued -> queue emptied, busy=1 next cycle, full sweep; the queued entries are never written.
- flush_req mid-sweep at idx 5, and rst_n pulse mid-sweep -> the sweep restarts at idx 0 and busy stays high for 8 more cycles.
